// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: one outstanding imem request at a time,
// returned instructions are presented to decode tagged with their PC.
//
// state   | meaning
// S_REQ   | request pc_q when not stalled or redirected
// S_WAIT  | request accepted, awaiting imem response
// S_HOLD  | instruction presented to decode until consumed or flushed
// S_FAULT | misaligned redirect seen, frozen until reset
module pc_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        stall,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready,
   output logic        misaligned_fault,
   output logic [31:0] fault_addr
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;

   state_t      state, state_n;
   logic [31:0] pc_q, pc_n;
   logic [31:0] req_pc, req_pc_n;
   logic        drop, drop_n;
   logic        if_valid_n;
   logic [31:0] if_instr_n, if_pc_n;
   logic        misaligned_fault_n;
   logic [31:0] fault_addr_n;
   logic        handshake;
   logic        target_bad;

   assign imem_addr      = pc_q;
   assign imem_req_valid = (state == S_REQ) & ~stall & ~branch_taken & ~rst;
   assign handshake      = imem_req_valid & imem_req_ready;
   assign target_bad     = branch_target[1:0] != 2'b00;

   always_comb begin
      state_n            = state;
      pc_n               = pc_q;
      req_pc_n           = req_pc;
      drop_n             = drop;
      if_valid_n         = if_valid;
      if_instr_n         = if_instr;
      if_pc_n            = if_pc;
      misaligned_fault_n = misaligned_fault;
      fault_addr_n       = fault_addr;

      case (state)
         S_REQ: begin
            if (branch_taken) begin
               pc_n = branch_target;
            end else if (handshake) begin
               req_pc_n = pc_q;
               pc_n     = pc_q + 32'd4;
               state_n  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (branch_taken && !imem_rsp_valid) begin
               pc_n   = branch_target;
               drop_n = 1'b1;
            end else if (imem_rsp_valid && (drop || branch_taken)) begin
               drop_n  = 1'b0;
               state_n = S_REQ;
               if (branch_taken) pc_n = branch_target;
            end else if (imem_rsp_valid) begin
               if_instr_n = imem_rdata;
               if_pc_n    = req_pc;
               if_valid_n = 1'b1;
               state_n    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (branch_taken) begin
               if_valid_n = 1'b0;
               pc_n       = branch_target;
               state_n    = S_REQ;
            end else if (if_ready) begin
               if_valid_n = 1'b0;
               state_n    = S_REQ;
            end
         end
         S_FAULT: begin
         end
         default: state_n = S_REQ;
      endcase

      // A misaligned redirect overrides whatever the state chose; pc_q is left alone.
      if (branch_taken && target_bad && (state != S_FAULT)) begin
         state_n            = S_FAULT;
         pc_n               = pc_q;
         drop_n             = 1'b0;
         if_valid_n         = 1'b0;
         misaligned_fault_n = 1'b1;
         fault_addr_n       = branch_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_REQ;
         pc_q             <= RESET_VECTOR;
         req_pc           <= 32'h0;
         drop             <= 1'b0;
         if_valid         <= 1'b0;
         if_instr         <= 32'h0;
         if_pc            <= 32'h0;
         misaligned_fault <= 1'b0;
         fault_addr       <= 32'h0;
      end else begin
         state            <= state_n;
         pc_q             <= pc_n;
         req_pc           <= req_pc_n;
         drop             <= drop_n;
         if_valid         <= if_valid_n;
         if_instr         <= if_instr_n;
         if_pc            <= if_pc_n;
         misaligned_fault <= misaligned_fault_n;
         fault_addr       <= fault_addr_n;
      end
   end

endmodule
